// File: rtl/alu_dispatcher.sv
// ALU command dispatcher: buffers commands in a FIFO and issues them one
// at a time to an external ALU, returning result or timeout downstream.
module alu_dispatcher #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [DATA_WIDTH-1:0] i_cmd_a,
    input  logic [DATA_WIDTH-1:0] i_cmd_b,
    input  logic [INST_WIDTH-1:0] i_cmd_inst,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [INST_WIDTH-1:0] o_alu_inst,
    output logic                  o_alu_valid,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic                  i_alu_overflow,
    input  logic                  i_alu_valid,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_overflow,
    output logic                  o_rsp_timeout,
    output logic                  o_busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [INST_WIDTH-1:0] inst;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    cmd_t                  mem_q [FIFO_DEPTH];
    cmd_t                  head;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         wcnt_q;
    state_t                state_q;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
    logic [INST_WIDTH-1:0] alu_inst_q;
    logic                  alu_valid_q;
    logic                  rsp_valid_q, rsp_ovf_q, rsp_to_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    assign o_cmd_ready = i_rst_n & (cnt_q < CW'(FIFO_DEPTH));
    assign push        = i_cmd_valid & o_cmd_ready;
    assign pop         = (state_q == S_IDLE) & (cnt_q != '0);
    assign head        = mem_q[rd_ptr_q];

    assign o_alu_a        = alu_a_q;
    assign o_alu_b        = alu_b_q;
    assign o_alu_inst     = alu_inst_q;
    assign o_alu_valid    = alu_valid_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_overflow = rsp_ovf_q;
    assign o_rsp_timeout  = rsp_to_q;
    assign o_busy         = (cnt_q != '0) | (state_q != S_IDLE);

    // FIFO pointer and occupancy next-state; pointers wrap at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= '{a: i_cmd_a, b: i_cmd_b, inst: i_cmd_inst};
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Issue/wait/respond sequencer with registered ALU and response outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_inst_q  <= '0;
            alu_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            alu_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cnt_q != '0) begin
                        alu_a_q     <= head.a;
                        alu_b_q     <= head.b;
                        alu_inst_q  <= head.inst;
                        alu_valid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wcnt_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_alu_valid) begin
                        rsp_data_q  <= i_alu_data;
                        rsp_ovf_q   <= i_alu_overflow;
                        rsp_to_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_ovf_q   <= 1'b0;
                        rsp_to_q    <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wcnt_q <= wcnt_q + TW'(1);
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_dispatcher.sv
// Self-checking bench for alu_dispatcher: behavioural ALU, response
// scoreboard and scenario tasks with randomized traffic.
module tb_alu_dispatcher;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int DEPTH = 4;
    localparam int TO = 15;
    localparam longint MAXS = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (DW - 1));

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [DW-1:0] i_cmd_a = '0, i_cmd_b = '0;
    logic [IW-1:0] i_cmd_inst = '0;
    logic [DW-1:0] o_alu_a, o_alu_b;
    logic [IW-1:0] o_alu_inst;
    logic          o_alu_valid;
    logic [DW-1:0] i_alu_data = 32'hdead_beef;
    logic          i_alu_overflow = 1'b1;
    logic          i_alu_valid;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_overflow, o_rsp_timeout, o_busy;
    logic          alu_vld_m = 1'b0, spur = 1'b0;

    assign i_alu_valid = alu_vld_m | spur;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          o;
        logic          t;
    } rsp_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [IW-1:0] inst;
        int            lat;
    } cmd_t;

    cmd_t iss_q[$];
    rsp_t exp_q[$];
    int   tests = 0, fails = 0, n_rsp = 0;
    bit   done;
    cmd_t rc;
    rsp_t rr, me;

    alu_dispatcher #(.DATA_WIDTH(DW), .INST_WIDTH(IW),
                     .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_inst(i_cmd_inst),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_inst(o_alu_inst),
        .o_alu_valid(o_alu_valid), .i_alu_data(i_alu_data),
        .i_alu_overflow(i_alu_overflow), .i_alu_valid(i_alu_valid),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_overflow(o_rsp_overflow),
        .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // ALU behaviour: 0 add, 1 sub (signed overflow), 2 and, 3 or; rest unsupported
    function automatic rsp_t alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [IW-1:0] inst);
        rsp_t x;
        longint r;
        x = '0;
        r = 0;
        if (inst == 4'd0) r = longint'($signed(a)) + longint'($signed(b));
        if (inst == 4'd1) r = longint'($signed(a)) - longint'($signed(b));
        if (inst == 4'd2) x.d = a & b;
        else if (inst == 4'd3) x.d = a | b;
        else begin
            x.d = r[DW-1:0];
            x.o = (r > MAXS) || (r < MINS);
        end
        return x;
    endfunction

    // Expected response: ALU answer if it arrives within the wait window, else timeout
    function automatic rsp_t model(input cmd_t c);
        rsp_t x;
        x = '0;
        if (c.inst > 4'd3 || c.lat >= TO) x.t = 1'b1;
        else x = alu_fn(c.a, c.b, c.inst);
        return x;
    endfunction

    // Behavioural ALU: answers lat cycles into the wait window
    initial forever begin
        @(negedge i_clk);
        if (o_alu_valid) begin
            tests++;
            if (iss_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_issue a=%h inst=%h", o_alu_a, o_alu_inst);
            end else begin
                rc = iss_q.pop_front();
                if ({o_alu_a, o_alu_b, o_alu_inst} !== {rc.a, rc.b, rc.inst}) begin
                    fails++;
                    $display("FAIL issue_order got %h/%h/%h want %h/%h/%h",
                             o_alu_a, o_alu_b, o_alu_inst, rc.a, rc.b, rc.inst);
                end
                if (rc.inst <= 4'd3 && rc.lat < TO) begin
                    rr = alu_fn(rc.a, rc.b, rc.inst);
                    repeat (rc.lat + 1) @(posedge i_clk);
                    #1;
                    i_alu_data = rr.d;
                    i_alu_overflow = rr.o;
                    alu_vld_m = 1'b1;
                    @(posedge i_clk);
                    #1;
                    alu_vld_m = 1'b0;
                    i_alu_data = $urandom;
                    i_alu_overflow = 1'b1;
                end
            end
        end
    end

    // Response scoreboard: every handshake must match the oldest expected entry
    initial forever begin
        @(negedge i_clk);
        if (o_rsp_valid && i_rsp_ready) begin
            n_rsp++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp got %h/%b/%b", o_rsp_data,
                         o_rsp_overflow, o_rsp_timeout);
            end else begin
                me = exp_q.pop_front();
                if ({o_rsp_data, o_rsp_overflow, o_rsp_timeout} !== me) begin
                    fails++;
                    $display("FAIL rsp_payload got %h/%b/%b want %h/%b/%b",
                             o_rsp_data, o_rsp_overflow, o_rsp_timeout,
                             me.d, me.o, me.t);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input cmd_t c);
        iss_q.push_back(c);
        exp_q.push_back(model(c));
        i_cmd_a = c.a;
        i_cmd_b = c.b;
        i_cmd_inst = c.inst;
        i_cmd_valid = 1'b1;
    endtask

    task automatic send(input cmd_t c);
        int g;
        g = 0;
        offer(c);
        while (!o_cmd_ready && g < 200) begin
            step();
            g++;
        end
        if (g == 200) begin
            tests++;
            fails++;
            $display("FAIL send_accept got ready=0 want ready=1 within 200 cycles");
        end
        step();
        i_cmd_valid = 1'b0;
    endtask

    function automatic cmd_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [IW-1:0] inst, input int lat);
        cmd_t c;
        c.a = a;
        c.b = b;
        c.inst = inst;
        c.lat = lat;
        return c;
    endfunction

    task automatic wait_rsp(output int n);
        n = 0;
        while (!o_rsp_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic drain(input int target, output bit ok);
        int g;
        g = 0;
        while (n_rsp < target && g < 3000) begin
            step();
            g++;
        end
        ok = (n_rsp >= target) && (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        tests++;
        if ({o_cmd_ready, o_busy, o_alu_valid, o_rsp_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs got ready/busy/av/rv=%b%b%b%b want 0000",
                     o_cmd_ready, o_busy, o_alu_valid, o_rsp_valid);
        end
        i_rst_n = 1'b1;
        #1;
        tests++;
        if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got ready=%b busy=%b want 1 0",
                     o_cmd_ready, o_busy);
        end
        step();
    endtask

    task automatic test_single();
        int base;
        base = n_rsp;
        i_rsp_ready = 1'b0;
        send(mk(32'd5, 32'd3, 4'd0, 0));
        tests++;
        if (o_alu_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early_issue got %b want 0", o_alu_valid);
        end
        step();
        tests++;
        if (o_alu_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_issue got %b want 1", o_alu_valid);
        end
        tests++;
        if ({o_alu_a, o_alu_b, o_alu_inst} !== {32'd5, 32'd3, 4'd0}) begin
            fails++;
            $display("FAIL single_operands got %h/%h/%h want 5/3/0",
                     o_alu_a, o_alu_b, o_alu_inst);
        end
        step();
        tests++;
        if (o_alu_valid !== 1'b0 || o_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_wait got av=%b rv=%b want 0 0", o_alu_valid, o_rsp_valid);
        end
        step();
        tests++;
        if (o_rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_latency got rv=%b want 1", o_rsp_valid);
        end
        tests++;
        if ({o_rsp_data, o_rsp_overflow, o_rsp_timeout} !== {32'd8, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL single_rsp got %h/%b/%b want 8/0/0",
                     o_rsp_data, o_rsp_overflow, o_rsp_timeout);
        end
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        tests++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || n_rsp != base + 1) begin
            fails++;
            $display("FAIL single_done got rv=%b busy=%b rsps=%0d want 0 0 %0d",
                     o_rsp_valid, o_busy, n_rsp - base, 1);
        end
    endtask

    task automatic test_timeout();
        logic [IW-1:0] insts[3];
        int lats[3];
        cmd_t c;
        rsp_t e;
        int g, n;
        insts = '{4'hF, 4'd0, 4'd1};
        lats = '{0, TO - 1, TO};
        for (int k = 0; k < 3; k++) begin
            i_rsp_ready = 1'b0;
            c = mk($urandom, $urandom, insts[k], lats[k]);
            e = model(c);
            send(c);
            g = 0;
            while (!o_alu_valid && g < 10) begin
                step();
                g++;
            end
            tests++;
            if (o_alu_valid !== 1'b1) begin
                fails++;
                $display("FAIL timeout_issue case %0d got av=0 want 1", k);
            end
            n = 0;
            while (!o_rsp_valid && n < 60) begin
                step();
                n++;
            end
            tests++;
            if (n != TO + 1) begin
                fails++;
                $display("FAIL timeout_cycles case %0d got %0d want %0d", k, n, TO + 1);
            end
            tests++;
            if ({o_rsp_data, o_rsp_overflow, o_rsp_timeout} !== e) begin
                fails++;
                $display("FAIL timeout_payload case %0d got %h/%b/%b want %h/%b/%b", k,
                         o_rsp_data, o_rsp_overflow, o_rsp_timeout, e.d, e.o, e.t);
            end
            i_rsp_ready = 1'b1;
            step();
            i_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_stall();
        cmd_t c0;
        rsp_t e;
        int base, n;
        bit ok;
        base = n_rsp;
        i_rsp_ready = 1'b0;
        c0 = mk($urandom, $urandom, 4'd1, 2);
        e = model(c0);
        send(c0);
        send(mk($urandom, $urandom, 4'd2, 0));
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (o_rsp_valid !== 1'b1 || o_alu_valid !== 1'b0 ||
                {o_rsp_data, o_rsp_overflow, o_rsp_timeout} !== e) begin
                fails++;
                $display("FAIL stall_hold cyc %0d got rv=%b av=%b %h/%b/%b want 1 0 %h/%b/%b",
                         i, o_rsp_valid, o_alu_valid, o_rsp_data, o_rsp_overflow,
                         o_rsp_timeout, e.d, e.o, e.t);
            end
            spur = (i == 3);
            step();
        end
        spur = 1'b0;
        i_rsp_ready = 1'b1;
        drain(base + 2, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_drain got %0d rsps want 2", n_rsp - base);
        end
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base, n;
        bit ok;
        base = n_rsp;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(mk($urandom, $urandom, 4'($urandom_range(0, 3)), $urandom_range(0, 3)));
        tests++;
        if (o_cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_full got ready=%b want 0", o_cmd_ready);
        end
        i_cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (o_cmd_ready !== 1'b0) begin
                fails++;
                $display("FAIL b2b_hold cyc %0d got ready=%b want 0", i, o_cmd_ready);
            end
            step();
        end
        i_cmd_valid = 1'b0;
        wait_rsp(n);
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        step();
        tests++;
        if (o_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_after_pop got ready=%b want 1", o_cmd_ready);
        end
        wait_rsp(n);
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        offer(mk($urandom, $urandom, 4'd0, 1));
        tests++;
        if (o_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL simul_pre got ready=%b want 1", o_cmd_ready);
        end
        step();
        i_cmd_valid = 1'b0;
        tests++;
        if (o_cmd_ready !== 1'b1 || o_alu_valid !== 1'b1) begin
            fails++;
            $display("FAIL simul_push_pop got ready=%b av=%b want 1 1",
                     o_cmd_ready, o_alu_valid);
        end
        send(mk($urandom, $urandom, 4'd3, 0));
        tests++;
        if (o_cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL simul_count got ready=%b want 0", o_cmd_ready);
        end
        i_rsp_ready = 1'b1;
        drain(base + 7, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_drain got %0d rsps want 7", n_rsp - base);
        end
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int base;
        bit ok;
        base = n_rsp;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send(mk($urandom, $urandom, 4'($urandom_range(0, 5)),
                            $urandom_range(0, TO + 1)));
                    repeat ($urandom_range(0, 2)) step();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    step();
                    i_rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        i_rsp_ready = 1'b1;
        drain(base + 24, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL random_drain got %0d rsps want 24", n_rsp - base);
        end
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int base, seen;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(mk($urandom, $urandom, 4'hE, 0));
        repeat (3) step();
        i_rst_n = 1'b0;
        #1;
        tests++;
        if ({o_busy, o_alu_valid, o_rsp_valid, o_cmd_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_flags got busy/av/rv/ready=%b%b%b%b want 0000",
                     o_busy, o_alu_valid, o_rsp_valid, o_cmd_ready);
        end
        tests++;
        if ({o_alu_a, o_alu_b, o_alu_inst, o_rsp_data, o_rsp_overflow, o_rsp_timeout} !== '0) begin
            fails++;
            $display("FAIL midrst_data got %h/%h/%h/%h/%b/%b want all 0", o_alu_a,
                     o_alu_b, o_alu_inst, o_rsp_data, o_rsp_overflow, o_rsp_timeout);
        end
        iss_q.delete();
        exp_q.delete();
        base = n_rsp;
        step();
        i_rst_n = 1'b1;
        i_rsp_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            step();
            if (o_alu_valid || o_rsp_valid || o_busy) seen++;
        end
        tests++;
        if (seen != 0 || n_rsp != base || o_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_after got active=%0d rsps=%0d ready=%b want 0 0 1",
                     seen, n_rsp - base, o_cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
